// File: rtl/jump_back_timer_if.sv
// jump_back_timer_if: bundles the obfuscation-FSM side of the jump-back timer.
//   fsm_flip       : FSM flip vector, nonzero while a jump-back is active
//   priority_flag  : FSM priority, pauses the ARMED deadline countdown
//   input_vec      : monitored primary inputs (LFSR entropy when mixing is built in)
//   comparator_sig : registered snapshot-freeze strobe to the core
//   state_o        : timer state (COUNT=0, ARMED=1, RECOVER=2, RESTORE=3)
//   jump_count     : saturating count of completed jump-backs
// master drives the FSM-side inputs; slave is the timer itself.
interface jump_back_timer_if #(
  parameter int fsm_out_len = 3,
  parameter int input_len   = 4
);
  logic [fsm_out_len-1:0] fsm_flip;
  logic                   priority_flag;
  logic [input_len-1:0]   input_vec;
  logic                   comparator_sig;
  logic [1:0]             state_o;
  logic [7:0]             jump_count;

  modport master (
    output fsm_flip, priority_flag, input_vec,
    input  comparator_sig, state_o, jump_count
  );

  modport slave (
    input  fsm_flip, priority_flag, input_vec,
    output comparator_sig, state_o, jump_count
  );
endinterface

// File: rtl/jump_back_timer.sv
// jump_back_timer: generates comparator_sig for the obfuscated sequential core.
// A seeded LFSR picks the trigger distance T; after T cycles in COUNT the strobe
// rises and is held through a deadline window (ARMED) and any jump-back
// (RECOVER) plus one restore cycle (RESTORE).
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   lfsr_seed : LFSR seed, sampled only while reset=1 (0 is replaced by 1)
//   bus       : jump_back_timer_if.slave (fsm_flip, priority_flag, input_vec,
//               comparator_sig, state_o, jump_count)
// Build option: define INPUT_MIX_EN to xor the parity of input_vec into the
// LFSR feedback.
module jump_back_timer #(
  parameter int                  lfsr_len    = 5,
  parameter logic [lfsr_len-1:0] lfsr_taps   = 5'b10100,
  parameter int                  counter_len = 7,
  parameter int                  deadline    = 5,
  parameter int                  fsm_out_len = 3,
  parameter int                  input_len   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [lfsr_len-1:0] lfsr_seed,
  jump_back_timer_if.slave    bus
);
  localparam int dl_w = (deadline > 1) ? $clog2(deadline) : 1;

  typedef enum logic [1:0] {COUNT = 2'd0, ARMED = 2'd1, RECOVER = 2'd2, RESTORE = 2'd3} state_t;

  state_t                 state, state_n;
  logic [counter_len-1:0] cnt, cnt_n, target;
  logic [dl_w-1:0]        dc, dc_n;
  logic [lfsr_len-1:0]    lfsr, lfsr_n, lfsr_step;
  logic [7:0]             jc, jc_n;
  logic                   comp;
  logic                   fb;
  logic [fsm_out_len-1:0] flip;
  logic [input_len-1:0]   in_vec;

  assign flip   = bus.fsm_flip;
  assign in_vec = bus.input_vec;
  assign target = counter_len'(lfsr);

`ifdef INPUT_MIX_EN
  always_comb begin
    fb        = (^(lfsr & lfsr_taps)) ^ (^in_vec);
    lfsr_step = {lfsr[lfsr_len-2:0], fb};
    // input entropy could drive the register to the all-zero lockup state
    if (lfsr_step == '0) lfsr_step = lfsr_len'(1);
  end
`else
  logic unused_in;
  assign unused_in = ^in_vec;
  always_comb begin
    fb        = ^(lfsr & lfsr_taps);
    lfsr_step = {lfsr[lfsr_len-2:0], fb};
  end
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dc_n    = dc;
    lfsr_n  = lfsr;
    jc_n    = jc;
    case (state)
      COUNT: begin
        if (cnt == target - counter_len'(1)) begin
          cnt_n   = '0;
          dc_n    = '0;
          lfsr_n  = lfsr_step;
          state_n = ARMED;
        end else begin
          cnt_n = cnt + counter_len'(1);
        end
      end
      ARMED: begin
        // a flip beats both the priority pause and deadline expiry
        if (flip != '0) begin
          state_n = RECOVER;
        end else if (bus.priority_flag) begin
          dc_n = dc;
        end else if (dc == dl_w'(deadline - 1)) begin
          state_n = COUNT;
          cnt_n   = '0;
        end else begin
          dc_n = dc + dl_w'(1);
        end
      end
      RECOVER: begin
        if (flip == '0) state_n = RESTORE;
      end
      RESTORE: begin
        state_n = COUNT;
        cnt_n   = '0;
        if (jc != 8'hFF) jc_n = jc + 8'd1;
      end
      default: state_n = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COUNT;
      cnt   <= '0;
      dc    <= '0;
      jc    <= '0;
      comp  <= 1'b0;
      lfsr  <= (lfsr_seed == '0) ? lfsr_len'(1) : lfsr_seed;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dc    <= dc_n;
      jc    <= jc_n;
      lfsr  <= lfsr_n;
      // strobe is high in every state but COUNT, registered against the next state
      comp  <= (state_n != COUNT);
    end
  end

  assign bus.comparator_sig = comp;
  assign bus.state_o        = state;
  assign bus.jump_count     = jc;
endmodule

// File: tb/tb_jump_back_timer.sv
module tb_jump_back_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] lfsr_seed = 5'b00001;
  int         passed = 0;
  int         total = 0;

  jump_back_timer_if bus ();

  jump_back_timer dut (
    .clk       (clk),
    .reset     (reset),
    .lfsr_seed (lfsr_seed),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] flip;
    logic       prio;
    logic       comp;
    logic [1:0] st;
    logic [7:0] jc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [2:0] flip, input logic prio,
                     input logic comp, input logic [1:0] st, input logic [7:0] jc, input int n);
    vec_t v;
    v.rst = rst; v.flip = flip; v.prio = prio; v.comp = comp; v.st = st; v.jc = jc;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // drive inputs on the falling edge, sample outputs 1ns after the rising edge
  task automatic step(input logic rst, input logic [2:0] flip, input logic prio);
    @(negedge clk);
    reset = rst;
    bus.fsm_flip = flip;
    bus.priority_flag = prio;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic comp, input logic [1:0] st, input logic [7:0] jc);
    total++;
    if (bus.comparator_sig === comp && bus.state_o === st && bus.jump_count === jc)
      passed++;
    else
      $display("FAIL %s: got comp=%b state=%0d jc=%0d, want comp=%b state=%0d jc=%0d",
               name, bus.comparator_sig, bus.state_o, bus.jump_count, comp, st, jc);
  endtask

  task automatic chk_comp(input string name, input logic comp);
    total++;
    if (bus.comparator_sig === comp) passed++;
    else $display("FAIL %s: got comp=%b want %b", name, bus.comparator_sig, comp);
  endtask

  task automatic wait_armed(input string name);
    int n = 0;
    while (bus.state_o !== 2'd1 && n < 64) begin
      step(1'b0, 3'd0, 1'b0);
      n++;
    end
    if (bus.state_o !== 2'd1) begin
      total++;
      $display("FAIL %s: timeout waiting for ARMED, state=%0d", name, bus.state_o);
    end
  endtask

  task automatic jump_once();
    wait_armed("jump_wait");
    step(1'b0, 3'd1, 1'b0);   // -> RECOVER
    step(1'b0, 3'd0, 1'b0);   // -> RESTORE
    step(1'b0, 3'd0, 1'b0);   // -> COUNT, count++
  endtask

  logic [7:0] seed0_pat;

  initial begin
    bus.fsm_flip = 3'd0;
    bus.priority_flag = 1'b0;
    bus.input_vec = 4'd0;

    // seed 0 must behave as seed 1: high 1-5, low 6-7, high at 8
    lfsr_seed = 5'b00000;
    step(1'b1, 3'd0, 1'b0);
    chk("seed0_reset", 1'b0, 2'd0, 8'd0);
    seed0_pat = 8'b1001_1111;   // bit i = expected comp after edge i+1
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 1'b0);
      chk_comp($sformatf("seed0_cyc%0d", i + 1), seed0_pat[i]);
    end

    // main table, seed 1; one row per clock edge
    lfsr_seed = 5'b00001;
    add(1, 0, 0, 0, 0, 0, 1);  // reset
    add(0, 0, 0, 1, 1, 0, 5);  // T=1: ARMED cycles 1-5
    add(0, 0, 0, 0, 0, 0, 2);  // COUNT 6-7, T=2
    add(0, 0, 0, 1, 1, 0, 2);  // ARMED at 8, second ARMED cycle 9
    add(0, 1, 0, 1, 2, 0, 3);  // flip for 3 cycles -> RECOVER
    add(0, 0, 0, 1, 3, 0, 1);  // RESTORE
    add(0, 0, 0, 0, 0, 1, 4);  // COUNT, T=4 (lfsr 00100)
    add(0, 0, 0, 1, 1, 1, 1);  // ARMED, lfsr -> 01001
    add(0, 0, 1, 1, 1, 1, 4);  // priority pause
    add(0, 0, 0, 1, 1, 1, 4);  // remaining deadline (9 ARMED cycles total)
    add(0, 0, 0, 0, 0, 1, 1);  // expiry -> COUNT, T=9
    add(0, 0, 1, 0, 0, 1, 2);  // priority ignored in COUNT
    add(0, 1, 0, 0, 0, 1, 4);  // flip ignored in COUNT
    add(0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 1, 1, 1, 5);  // ARMED, deadline counter reaches 4
    add(0, 1, 0, 1, 2, 1, 1);  // flip on final ARMED cycle wins
    add(0, 0, 0, 1, 3, 1, 1);
    add(0, 0, 0, 0, 0, 2, 1);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flip, tbl[i].prio);
      chk($sformatf("tbl%0d", i), tbl[i].comp, tbl[i].st, tbl[i].jc);
    end

    // saturation: 2 jumps so far, 258 more
    for (int i = 1; i <= 258; i++) begin
      jump_once();
      if (i == 252) chk("jc_254", 1'b0, 2'd0, 8'd254);
      if (i == 253) chk("jc_255", 1'b0, 2'd0, 8'd255);
    end
    chk("jc_sat", 1'b0, 2'd0, 8'd255);

    // reset during RECOVER, new seed 3 -> first trigger after 3 cycles
    wait_armed("rst_wait");
    step(1'b0, 3'd2, 1'b0);
    chk("in_recover", 1'b1, 2'd2, 8'd255);
    lfsr_seed = 5'b00011;
    step(1'b1, 3'd2, 1'b0);
    chk("mid_reset", 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("seed3_c1", 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("seed3_c2", 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("seed3_c3", 1'b1, 2'd1, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
